// File: rtl/block_sum_collector.sv
// Collects the per-group result words of the block-sum engine after each Ready
// rising edge and streams them out through a small valid/ready FIFO.
module block_sum_collector #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int GROUP_SIZE = 8,
  parameter int NUM_GROUPS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SumReady,
  output logic              BusReq,
  input  logic              BusGrant,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  input  logic [DATA_W-1:0] DataOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  output logic [1:0]        OutIndex,
  output logic              OutLast,
  output logic [7:0]        FrameCount,
  output logic              Overrun
);

  localparam int G_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int P_W = $clog2(FIFO_DEPTH);
  localparam int C_W = P_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [G_W-1:0]    g_r, g_s;
  logic              sum_ready_q_r;
  logic              start_s;
  logic              last_grp_s;
  logic              push_s;
  logic              pop_s;
  logic              bus_req_s;
  logic              fifo_full_s;
  logic [ADDR_W-1:0] grp_addr_s;
  logic [ADDR_W-1:0] addr_s;
  logic [P_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [C_W-1:0]    count_r;
  logic [DATA_W-1:0] fifo_data_r [FIFO_DEPTH];
  logic [1:0]        fifo_idx_r  [FIFO_DEPTH];
  logic              fifo_last_r [FIFO_DEPTH];
  logic [7:0]        frame_count_r;
  logic              overrun_r;

  assign start_s     = SumReady && !sum_ready_q_r;
  assign last_grp_s  = (g_r == G_W'(NUM_GROUPS - 1));
  assign grp_addr_s  = ADDR_W'(g_r) * ADDR_W'(GROUP_SIZE) + ADDR_W'(GROUP_SIZE - 1);
  assign fifo_full_s = (count_r == C_W'(FIFO_DEPTH));
  assign OutValid    = (count_r != {C_W{1'b0}});
  assign pop_s       = OutValid && OutReady;

  assign BusReq      = bus_req_s;
  assign ReadEnable  = push_s;
  assign Address     = addr_s;
  assign FrameCount  = frame_count_r;
  assign Overrun     = overrun_r;
  // Head is forced to zero when empty so an idle stream shows reset values.
  assign OutData     = OutValid ? fifo_data_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign OutIndex    = OutValid ? fifo_idx_r[rd_ptr_r]  : 2'b00;
  assign OutLast     = OutValid ? fifo_last_r[rd_ptr_r] : 1'b0;

  // Next-state, group advance and read-port strobes.
  always_comb begin
    state_s   = state_r;
    g_s       = g_r;
    push_s    = 1'b0;
    bus_req_s = 1'b0;
    addr_s    = {ADDR_W{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_REQ;
          g_s     = {G_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        bus_req_s = 1'b1;
        addr_s    = grp_addr_s;
        // A stalled cycle keeps g so no group is skipped or read twice.
        if (BusGrant && !fifo_full_s) begin
          push_s = 1'b1;
          if (last_grp_s) begin
            state_s = ST_IDLE;
            g_s     = {G_W{1'b0}};
          end else begin
            g_s = g_r + G_W'(1'b1);
          end
        end else begin
          g_s = g_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        g_s     = {G_W{1'b0}};
      end
    endcase
  end

  // FSM state, edge detector, frame counter and sticky overrun flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r       <= ST_IDLE;
      g_r           <= {G_W{1'b0}};
      sum_ready_q_r <= 1'b0;
      frame_count_r <= 8'd0;
      overrun_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      g_r           <= g_s;
      sum_ready_q_r <= SumReady;
      if (push_s && last_grp_s) begin
        frame_count_r <= frame_count_r + 8'd1;
      end
      if (start_s && (state_r != ST_IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // Output FIFO storage and pointers; full already blocks push, so push+pop never overflows.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_r <= {P_W{1'b0}};
      rd_ptr_r <= {P_W{1'b0}};
      count_r  <= {C_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= {DATA_W{1'b0}};
        fifo_idx_r[i]  <= 2'b00;
        fifo_last_r[i] <= 1'b0;
      end
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= DataOut;
        fifo_idx_r[wr_ptr_r]  <= 2'(g_r);
        fifo_last_r[wr_ptr_r] <= last_grp_s;
        wr_ptr_r              <= wr_ptr_r + P_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + P_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + C_W'(1'b1);
        2'b01:   count_r <= count_r - C_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_block_sum_collector.sv
// Randomized self-checking bench for block_sum_collector: a behavioural memory,
// a stream monitor and per-scenario tasks comparing against an expected frame model.
module tb_block_sum_collector;

  logic        Clock;
  logic        Reset;
  logic        SumReady;
  logic        BusReq;
  logic        BusGrant;
  logic [4:0]  Address;
  logic        ReadEnable;
  logic [15:0] DataOut;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] OutData;
  logic [1:0]  OutIndex;
  logic        OutLast;
  logic [7:0]  FrameCount;
  logic        Overrun;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [32];
  logic [18:0] rx_q [$];
  logic [4:0]  rd_addr_q [$];
  int          rd_cyc_q [$];
  int          viol = 0;
  int          stab_err = 0;
  int          cyc = 0;
  logic        prev_hold = 1'b0;
  logic [18:0] prev_word = 19'd0;

  block_sum_collector #(
    .DATA_W(16), .ADDR_W(5), .GROUP_SIZE(8), .NUM_GROUPS(4), .FIFO_DEPTH(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .SumReady(SumReady), .BusReq(BusReq),
    .BusGrant(BusGrant), .Address(Address), .ReadEnable(ReadEnable),
    .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady),
    .OutData(OutData), .OutIndex(OutIndex), .OutLast(OutLast),
    .FrameCount(FrameCount), .Overrun(Overrun)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  assign DataOut = ReadEnable ? mem[Address] : 16'h0000;

  // Stream monitor: records reads, accepted words and protocol violations.
  always @(negedge Clock) begin
    cyc = cyc + 1;
    if (Reset) begin
      if (ReadEnable) begin
        rd_addr_q.push_back(Address);
        rd_cyc_q.push_back(cyc);
        if (!BusGrant) viol = viol + 1;
      end
      if (prev_hold && OutValid && ({OutIndex, OutLast, OutData} !== prev_word))
        stab_err = stab_err + 1;
      prev_hold = OutValid && !OutReady;
      prev_word = {OutIndex, OutLast, OutData};
      if (OutValid && OutReady) rx_q.push_back({OutIndex, OutLast, OutData});
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Expected output word for group g of the frame held in mem.
  function automatic logic [18:0] exp_word(int g);
    return {2'(g), 1'(g == 3), mem[g*8+7]};
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic clear_q();
    rx_q.delete();
    rd_addr_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic do_reset();
    Reset = 1'b0; SumReady = 1'b0; BusGrant = 1'b0; OutReady = 1'b1;
    step(2);
    clear_q();
    viol = 0; stab_err = 0;
    Reset = 1'b1;
    step(1);
  endtask

  task automatic fill_rand();
    for (int g = 0; g < 4; g++) mem[g*8+7] = 16'($urandom);
  endtask

  task automatic fire();
    SumReady = 1'b1;
    step(1);
  endtask

  task automatic wait_done(int frames, int words);
    int n = 0;
    while ((FrameCount != 8'(frames) || rx_q.size() < words) && n < 300) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_done: FrameCount=%0d words=%0d, required %0d/%0d", FrameCount, rx_q.size(), frames, words);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; SumReady = 1'b0; BusGrant = 1'b0; OutReady = 1'b1;
    #3 Reset = 1'b0;
    #1;
    checks++;
    if ({BusReq, ReadEnable, OutValid, OutLast, Overrun} !== 5'b00000) begin
      errors++; $display("FAIL reset_flags: got %b, required 00000", {BusReq, ReadEnable, OutValid, OutLast, Overrun});
    end
    checks++;
    if ({Address, OutData, OutIndex, FrameCount} !== 31'd0) begin
      errors++; $display("FAIL reset_values: addr=%0d data=%0d idx=%0d fc=%0d, required 0", Address, OutData, OutIndex, FrameCount);
    end
  endtask

  task automatic test_basic();
    do_reset();
    mem[7] = 16'd7; mem[15] = 16'd14; mem[23] = 16'd70; mem[31] = 16'd35;
    BusGrant = 1'b1;
    fire();
    wait_done(1, 4);
    checks++;
    if (rx_q.size() != 4 || rd_addr_q.size() != 4) begin
      errors++; $display("FAIL basic_count: words=%0d reads=%0d, required 4/4", rx_q.size(), rd_addr_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rx_q[g] !== exp_word(g) || rd_addr_q[g] !== 5'(g*8+7)) begin
          errors++; $display("FAIL basic_word%0d: got %h@%0d, required %h@%0d", g, rx_q[g], rd_addr_q[g], exp_word(g), g*8+7);
        end
      end
      checks++;
      if (rd_cyc_q[3] - rd_cyc_q[0] !== 3) begin
        errors++; $display("FAIL basic_consecutive: span %0d, required 3", rd_cyc_q[3] - rd_cyc_q[0]);
      end
    end
    checks++;
    if (FrameCount !== 8'd1 || Overrun !== 1'b0 || viol != 0) begin
      errors++; $display("FAIL basic_status: fc=%0d ovr=%b viol=%0d, required 1/0/0", FrameCount, Overrun, viol);
    end
    SumReady = 1'b0;
  endtask

  task automatic test_grant_stall();
    do_reset();
    fill_rand();
    BusGrant = 1'b1;
    fire();
    step(1);
    BusGrant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checks++;
      if (ReadEnable !== 1'b0 || Address !== 5'd15 || BusReq !== 1'b1) begin
        errors++; $display("FAIL stall_cycle%0d: re=%b addr=%0d req=%b, required 0/15/1", k, ReadEnable, Address, BusReq);
      end
    end
    step(1);
    BusGrant = 1'b1;
    wait_done(1, 4);
    checks++;
    if (rx_q.size() != 4 || rd_addr_q.size() != 4) begin
      errors++; $display("FAIL stall_count: words=%0d reads=%0d, required 4/4", rx_q.size(), rd_addr_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rx_q[g] !== exp_word(g)) begin
          errors++; $display("FAIL stall_word%0d: got %h, required %h", g, rx_q[g], exp_word(g));
        end
      end
    end
    SumReady = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_rand();
    BusGrant = 1'b1;
    OutReady = 1'b0;
    fire();
    step(6);
    @(negedge Clock);
    checks++;
    if (BusReq !== 1'b1 || ReadEnable !== 1'b0 || rd_addr_q.size() != 2) begin
      errors++; $display("FAIL bp_stall: req=%b re=%b reads=%0d, required 1/0/2", BusReq, ReadEnable, rd_addr_q.size());
    end
    checks++;
    if (OutValid !== 1'b1 || {OutIndex, OutLast, OutData} !== exp_word(0) || rx_q.size() != 0) begin
      errors++; $display("FAIL bp_head: valid=%b word=%h, required 1/%h", OutValid, {OutIndex, OutLast, OutData}, exp_word(0));
    end
    step(1);
    OutReady = 1'b1;
    wait_done(1, 4);
    checks++;
    if (rx_q.size() != 4) begin
      errors++; $display("FAIL bp_count: words=%0d, required 4", rx_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rx_q[g] !== exp_word(g)) begin
          errors++; $display("FAIL bp_word%0d: got %h, required %h", g, rx_q[g], exp_word(g));
        end
      end
    end
    SumReady = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    fill_rand();
    fire();
    step(3);
    SumReady = 1'b0;
    step(2);
    SumReady = 1'b1;
    step(2);
    @(negedge Clock);
    checks++;
    if (Overrun !== 1'b1 || rd_addr_q.size() != 0) begin
      errors++; $display("FAIL ovr_flag: ovr=%b reads=%0d, required 1/0", Overrun, rd_addr_q.size());
    end
    step(1);
    BusGrant = 1'b1;
    wait_done(1, 4);
    for (int g = 0; g < 4 && rx_q.size() == 4; g++) begin
      checks++;
      if (rx_q[g] !== exp_word(g)) begin
        errors++; $display("FAIL ovr_word%0d: got %h, required %h", g, rx_q[g], exp_word(g));
      end
    end
    SumReady = 1'b0;
    step(5);
    checks++;
    if (FrameCount !== 8'd1 || rx_q.size() != 4) begin
      errors++; $display("FAIL ovr_single: fc=%0d words=%0d, required 1/4", FrameCount, rx_q.size());
    end
    mem[7] = 16'd21; mem[15] = 16'd77; mem[23] = 16'd133; mem[31] = 16'd189;
    clear_q();
    fire();
    wait_done(2, 4);
    for (int g = 0; g < 4 && rx_q.size() == 4; g++) begin
      checks++;
      if (rx_q[g] !== exp_word(g)) begin
        errors++; $display("FAIL ovr2_word%0d: got %h, required %h", g, rx_q[g], exp_word(g));
      end
    end
    checks++;
    if (FrameCount !== 8'd2 || Overrun !== 1'b1) begin
      errors++; $display("FAIL ovr2_status: fc=%0d ovr=%b, required 2/1", FrameCount, Overrun);
    end
    SumReady = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    do_reset();
    fill_rand();
    BusGrant = 1'b1;
    fire();
    while (rd_addr_q.size() < 2 && n < 50) begin
      @(negedge Clock);
      n++;
    end
    @(posedge Clock);
    #2 Reset = 1'b0;
    SumReady = 1'b0;
    #1;
    checks++;
    if ({BusReq, ReadEnable, OutValid, OutLast, Overrun} !== 5'b00000 ||
        {Address, OutData, OutIndex, FrameCount} !== 31'd0 || n >= 50) begin
      errors++; $display("FAIL midreset: req=%b re=%b valid=%b addr=%0d data=%0d fc=%0d, required all 0",
                         BusReq, ReadEnable, OutValid, Address, OutData, FrameCount);
    end
    step(2);
    Reset = 1'b1;
    clear_q();
    step(1);
    fire();
    wait_done(1, 4);
    checks++;
    if (rx_q.size() != 4) begin
      errors++; $display("FAIL midreset_count: words=%0d, required 4", rx_q.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (rx_q[g] !== exp_word(g)) begin
          errors++; $display("FAIL midreset_word%0d: got %h, required %h", g, rx_q[g], exp_word(g));
        end
      end
    end
    SumReady = 1'b0;
  endtask

  task automatic test_level_high();
    do_reset();
    fill_rand();
    BusGrant = 1'b1;
    fire();
    wait_done(1, 4);
    step(100);
    checks++;
    if (FrameCount !== 8'd1 || rd_addr_q.size() != 4 || rx_q.size() != 4 || BusReq !== 1'b0) begin
      errors++; $display("FAIL level_high: fc=%0d reads=%0d words=%0d req=%b, required 1/4/4/0",
                         FrameCount, rd_addr_q.size(), rx_q.size(), BusReq);
    end
    SumReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      int n = 0;
      fill_rand();
      clear_q();
      fire();
      while ((FrameCount != 8'(f) || rx_q.size() < 4) && n < 400) begin
        BusGrant = 1'($urandom_range(0, 1));
        OutReady = 1'($urandom_range(0, 1));
        step(1);
        n++;
      end
      BusGrant = 1'b0;
      OutReady = 1'b1;
      checks++;
      if (n >= 400 || rx_q.size() != 4) begin
        errors++; $display("FAIL b2b_frame%0d: fc=%0d words=%0d, required %0d/4", f, FrameCount, rx_q.size(), f);
      end else begin
        for (int g = 0; g < 4; g++) begin
          checks++;
          if (rx_q[g] !== exp_word(g)) begin
            errors++; $display("FAIL b2b_f%0d_word%0d: got %h, required %h", f, g, rx_q[g], exp_word(g));
          end
        end
      end
      SumReady = 1'b0;
      step(1);
    end
    checks++;
    if (viol != 0 || stab_err != 0 || Overrun !== 1'b0) begin
      errors++; $display("FAIL b2b_protocol: viol=%0d unstable=%0d ovr=%b, required 0/0/0", viol, stab_err, Overrun);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    test_reset();
    test_basic();
    test_grant_stall();
    test_backpressure();
    test_overrun();
    test_reset_midframe();
    test_level_high();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
